// File: rtl/reg_file_cc.sv
// General register file with condition codes {N,Z,P} and branch-enable flag.
// Optional macro REG_WRITE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_cc #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LD_REG,
    input  logic [2:0]       DR,
    input  logic [WIDTH-1:0] BUS,
    input  logic [2:0]       SR1,
    input  logic [2:0]       SR2,
    output logic [WIDTH-1:0] SR1_OUT,
    output logic [WIDTH-1:0] SR2_OUT,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [2:0]       IR_NZP,
    output logic [2:0]       NZP,
    output logic             BEN
);

    logic [WIDTH-1:0] regs [NREG];
    logic [2:0]       nzp_q;
    logic             ben_q;
    logic [WIDTH-1:0] stored_1;
    logic [WIDTH-1:0] stored_2;

    // Exactly one code bit is ever set: negative, zero, or positive.
    function automatic logic [2:0] cc_decode(input logic [WIDTH-1:0] value);
        if (value[WIDTH-1])
            return 3'b100;
        else if (value == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    // Indices beyond NREG (when NREG < 8) read as zero and are never written.
    function automatic logic in_range(input logic [2:0] idx);
        return int'({29'd0, idx}) < NREG;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (LD_REG && in_range(DR)) begin
            regs[DR] <= BUS;
        end
    end

    // BEN samples nzp_q before this edge, so a simultaneous LD_CC is not seen.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (LD_CC)
                nzp_q <= cc_decode(BUS);
            if (LD_BEN)
                ben_q <= |(IR_NZP & nzp_q);
        end
    end

    always_comb begin
        stored_1 = '0;
        stored_2 = '0;
        if (in_range(SR1))
            stored_1 = regs[SR1];
        if (in_range(SR2))
            stored_2 = regs[SR2];
    end

`ifdef REG_WRITE_BYPASS_EN
    assign SR1_OUT = (LD_REG && in_range(DR) && (DR == SR1)) ? BUS : stored_1;
    assign SR2_OUT = (LD_REG && in_range(DR) && (DR == SR2)) ? BUS : stored_2;
`else
    assign SR1_OUT = stored_1;
    assign SR2_OUT = stored_2;
`endif

    assign NZP = nzp_q;
    assign BEN = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
// Bench for reg_file_cc: directed vector table, hand sequences, and random traffic vs. a reference model.
module tb_reg_file_cc;
    localparam int WIDTH = 16;
    localparam int NREG  = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             LD_REG, LD_CC, LD_BEN;
    logic [2:0]       DR, SR1, SR2, IR_NZP, NZP;
    logic [WIDTH-1:0] BUS, SR1_OUT, SR2_OUT;
    logic             BEN;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_r [8];
    logic [2:0]  m_nzp;
    logic        m_ben;

    reg_file_cc #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .CLK(CLK), .RST_N(RST_N), .LD_REG(LD_REG), .DR(DR), .BUS(BUS),
        .SR1(SR1), .SR2(SR2), .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT),
        .LD_CC(LD_CC), .LD_BEN(LD_BEN), .IR_NZP(IR_NZP), .NZP(NZP), .BEN(BEN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ld_reg;
        logic [2:0]  dr;
        logic [15:0] bus;
        logic        ld_cc;
        logic        ld_ben;
        logic [2:0]  ir_nzp;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [15:0] exp_sr1;
        logic [15:0] exp_sr2;
        logic [2:0]  exp_nzp;
        logic        exp_ben;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] exp_read(input logic [2:0] sel);
`ifdef REG_WRITE_BYPASS_EN
        if (LD_REG && DR == sel) return BUS;
`endif
        return m_r[sel];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
        m_nzp = 3'b010;
        m_ben = 1'b0;
    endtask

    task automatic drive(input logic ld_reg, input logic [2:0] dr, input logic [15:0] bus,
                         input logic ld_cc, input logic ld_ben, input logic [2:0] ir,
                         input logic [2:0] s1, input logic [2:0] s2);
        LD_REG = ld_reg; DR = dr; BUS = bus; LD_CC = ld_cc;
        LD_BEN = ld_ben; IR_NZP = ir; SR1 = s1; SR2 = s2;
    endtask

    // Advance the model with the inputs currently applied, then take the edge.
    task automatic clk_step();
        if (LD_BEN) m_ben = (IR_NZP & m_nzp) != 3'b000;
        if (LD_CC)  m_nzp = cc_of(BUS);
        if (LD_REG) m_r[DR] = BUS;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b1;
        drive(1'b1, 3'd1, 16'h1111, 1'b1, 1'b1, 3'b111, 3'd1, 3'd0);
        #1 RST_N = 1'b0;
        #1;
        chk("reset_sr1_async", SR1_OUT, 16'h0000);
        chk("reset_sr2_async", SR2_OUT, 16'h0000);
        chk("reset_nzp_async", NZP, 3'b010);
        chk("reset_ben_async", BEN, 1'b0);
        @(posedge CLK); @(posedge CLK); #1;
        chk("reset_hold_sr1", SR1_OUT, 16'h0000);
        chk("reset_hold_nzp", NZP, 3'b010);
        chk("reset_hold_ben", BEN, 1'b0);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0);
        RST_N = 1'b1;
        model_reset();

        vecs[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 3'b000, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b010, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 16'h8000, 1'b1, 1'b0, 3'b000, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b100, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'b000, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b010, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 16'h7FFF, 1'b1, 1'b0, 3'b000, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b001, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'b000, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b010, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 16'h0005, 1'b1, 1'b1, 3'b010, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b001, 1'b1};
        vecs[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b010, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b001, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b000, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b001, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b111, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b001, 1'b1};
        vecs[9]  = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 3'b000, 3'd7, 3'd3, 16'hFFFF, 16'h1234, 3'b100, 1'b1};
        vecs[10] = '{1'b0, 3'd7, 16'h0000, 1'b0, 1'b0, 3'b000, 3'd7, 3'd0, 16'hFFFF, 16'h0000, 3'b100, 1'b1};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].ld_reg, vecs[i].dr, vecs[i].bus, vecs[i].ld_cc,
                  vecs[i].ld_ben, vecs[i].ir_nzp, vecs[i].sr1, vecs[i].sr2);
            clk_step();
            drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, vecs[i].sr1, vecs[i].sr2);
            #1;
            chk($sformatf("vec%0d_sr1", i), SR1_OUT, vecs[i].exp_sr1);
            chk($sformatf("vec%0d_sr2", i), SR2_OUT, vecs[i].exp_sr2);
            chk($sformatf("vec%0d_nzp", i), NZP, vecs[i].exp_nzp);
            chk($sformatf("vec%0d_ben", i), BEN, vecs[i].exp_ben);
        end

        // Same-index write and read in one cycle.
        drive(1'b1, 3'd5, 16'h00AA, 1'b0, 1'b0, 3'b000, 3'd5, 3'd5);
        clk_step();
        drive(1'b1, 3'd5, 16'h0055, 1'b0, 1'b0, 3'b000, 3'd5, 3'd5);
        #2;
`ifdef REG_WRITE_BYPASS_EN
        chk("bypass_sr1_pre", SR1_OUT, 16'h0055);
        chk("bypass_sr2_pre", SR2_OUT, 16'h0055);
`else
        chk("bypass_sr1_pre", SR1_OUT, 16'h00AA);
        chk("bypass_sr2_pre", SR2_OUT, 16'h00AA);
`endif
        clk_step();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, 3'd5, 3'd5);
        #1;
        chk("bypass_sr1_post", SR1_OUT, 16'h0055);
        chk("bypass_sr2_post", SR2_OUT, 16'h0055);

        // Reset asserted while a write and CC load are pending.
        drive(1'b1, 3'd2, 16'hBEEF, 1'b1, 1'b1, 3'b111, 3'd2, 3'd5);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_sr2", SR2_OUT, 16'h0000);
        chk("midrst_nzp", NZP, 3'b010);
        chk("midrst_ben", BEN, 1'b0);
        @(posedge CLK); #1;
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, 3'd2, 3'd5);
        RST_N = 1'b1;
        model_reset();
        #1;
        chk("midrst_r2", SR1_OUT, 16'h0000);
        chk("midrst_r5", SR2_OUT, 16'h0000);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [15:0] rb;
            case ($urandom_range(0, 3))
                0: rb = 16'h0000;
                1: rb = 16'h8000 | 16'($urandom);
                default: rb = 16'($urandom);
            endcase
            drive(1'($urandom), 3'($urandom), rb, 1'($urandom), 1'($urandom),
                  3'($urandom), 3'($urandom), 3'($urandom));
            #3;
            chk("rnd_sr1", SR1_OUT, exp_read(SR1));
            chk("rnd_sr2", SR2_OUT, exp_read(SR2));
            clk_step();
            chk("rnd_nzp", NZP, m_nzp);
            chk("rnd_ben", BEN, m_ben);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_cc.md
REG_FILE_CC -- requirements
Module: reg_file_cc

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data width of registers, bus and read ports.
REQ-002 SHALL provide parameter NREG, default 8, number of general registers; address width fixed at 3 bits.
REQ-003 SHALL provide port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port LD_REG  input  1  write-enable for register file.
REQ-006 SHALL provide port DR  input  3  destination register index.
REQ-007 SHALL provide port BUS  input  WIDTH  write data and condition-code source.
REQ-008 SHALL provide port SR1  input  3  read port 1 index.
REQ-009 SHALL provide port SR2  input  3  read port 2 index.
REQ-010 SHALL provide port SR1_OUT  output  WIDTH  read port 1 data; drives ALU operand A.
REQ-011 SHALL provide port SR2_OUT  output  WIDTH  read port 2 data; drives ALU operand B path.
REQ-012 SHALL provide port LD_CC  input  1  condition-code load enable.
REQ-013 SHALL provide port LD_BEN  input  1  branch-enable load enable.
REQ-014 SHALL provide port IR_NZP  input  3  branch condition bits IR[11:9], order {n,z,p}.
REQ-015 SHALL provide port NZP  output  3  registered condition codes {N,Z,P}.
REQ-016 SHALL provide port BEN  output  1  registered branch enable.

Function
REQ-017 Reads SHALL be combinational: SRx_OUT = R[SRx], no clock latency.
REQ-018 On rising CLK with LD_REG=1, R[DR] SHALL take BUS; other registers unchanged; LD_REG=0 leaves all unchanged.
REQ-019 On rising CLK with LD_CC=1, NZP SHALL load 100 if BUS[WIDTH-1]=1, 010 if BUS==0, else 001; exactly one bit set at all times.
REQ-020 On rising CLK with LD_BEN=1, BEN SHALL load |(IR_NZP & NZP) using the NZP value held before that edge.
REQ-021 LD_CC and LD_BEN in the same cycle: BEN SHALL use old NZP; NZP updates simultaneously.
REQ-022 LD_REG and LD_CC in the same cycle SHALL be independent; both take effect from the same BUS value.
REQ-023 Write and read of same index in same cycle: read SHALL return pre-write value unless REQ-029 applies.
REQ-024 IR_NZP=000 SHALL yield BEN=0; IR_NZP=111 SHALL yield BEN=1 on load.
REQ-025 All register widths SHALL be exactly WIDTH; no sign extension or truncation on write.

Reset
REQ-026 RST_N=0 SHALL immediately, independent of CLK, clear R[0..NREG-1] to 0, set NZP=010, clear BEN=0.
REQ-027 While RST_N=0 all writes and loads SHALL be ignored; first update occurs on first rising CLK after RST_N returns high.
REQ-028 Reset asserted mid-sequence SHALL discard any pending same-cycle write; no partial update.

Configuration
REQ-029 With macro REG_WRITE_BYPASS_EN defined, SRx_OUT SHALL return BUS when LD_REG=1 and DR==SRx (same-cycle forwarding), both ports independently.
REQ-030 Without REG_WRITE_BYPASS_EN, SRx_OUT SHALL always return stored R[SRx] (REQ-023 behaviour); no other difference.

Verification
REQ-031 Reset: drive RST_N=0 between edges -> all SR reads 0x0000, NZP=010, BEN=0 without a clock edge.
REQ-032 Write/read: LD_REG=1, DR=3, BUS=0x1234, edge; SR1=3, SR2=0 -> SR1_OUT=0x1234, SR2_OUT=0x0000.
REQ-033 CC: LD_CC with BUS=0x8000 -> NZP=100; BUS=0x0000 -> 010; BUS=0x7FFF -> 001.
REQ-034 BEN ordering: NZP=010, same cycle LD_CC BUS=0x0005 and LD_BEN IR_NZP=010 -> BEN=1, NZP=001; next LD_BEN IR_NZP=010 -> BEN=0.
REQ-035 Bypass: R[5]=0x00AA, LD_REG=1 DR=5 BUS=0x0055, SR1=5 before edge -> SR1_OUT=0x0055 with REG_WRITE_BYPASS_EN, 0x00AA without; 0x0055 after edge in both.
